// File: rtl/scan_decoder_pkg.sv
// Shared state encoding and mode constants for scan_decoder.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_BLANK  = 2'd3
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_decoder.sv
// Combinational binary-to-one-hot decode; codes at or above OUT_W give all zeros.
module onehot_decoder #(
    parameter int SEL_W = 4,
    parameter int OUT_W = 16
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (sel == SEL_W'(i)) dout[i] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with DIRECT decode and autonomous SCAN sweep.
// Define SCAN_DECODER_BLANK_GAP_EN to insert one blank cycle between scan steps.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int OUT_W   = 16,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   dout,
    output logic [SEL_W-1:0]   cur_idx,
    output logic               wrap,
    output logic               busy
);

`ifdef SCAN_DECODER_BLANK_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    state_t             state, nxt_state;
    logic [DWELL_W-1:0] cnt, nxt_cnt;
    logic [SEL_W-1:0]   nxt_idx, adv_idx;
    logic [OUT_W-1:0]   dec_out;
    logic               nxt_show, nxt_wrap, nxt_busy, at_last;

    assign at_last = (cur_idx == LAST_IDX);
    assign adv_idx = at_last ? '0 : cur_idx + SEL_W'(1);

    always_comb begin
        nxt_state = state;
        nxt_idx   = cur_idx;
        nxt_cnt   = cnt;
        nxt_show  = 1'b0;
        nxt_wrap  = 1'b0;
        nxt_busy  = 1'b0;
        if (!en) begin
            nxt_state = ST_IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else if (mode == MODE_DIRECT) begin
            nxt_state = ST_DIRECT;
            nxt_idx   = sel_in;
            nxt_cnt   = '0;
            nxt_show  = 1'b1;
        end else if (state == ST_IDLE || state == ST_DIRECT) begin
            nxt_state = ST_SCAN;
            nxt_idx   = '0;
            nxt_cnt   = dwell;
            nxt_show  = 1'b1;
            nxt_busy  = 1'b1;
        end else if (state == ST_SCAN && cnt != '0) begin
            nxt_cnt  = cnt - DWELL_W'(1);
            nxt_show = 1'b1;
            nxt_busy = 1'b1;
        end else if (GAP && state == ST_SCAN) begin
            // Dwell expired: blank for one cycle, index held until the next step.
            nxt_state = ST_BLANK;
            nxt_busy  = 1'b1;
        end else begin
            // Step boundary: dwell is sampled here so mid-step changes wait a step.
            nxt_state = ST_SCAN;
            nxt_idx   = adv_idx;
            nxt_cnt   = dwell;
            nxt_show  = 1'b1;
            nxt_busy  = 1'b1;
            nxt_wrap  = at_last;
        end
    end

    onehot_decoder #(
        .SEL_W(SEL_W),
        .OUT_W(OUT_W)
    ) u_dec (
        .sel (nxt_idx),
        .dout(dec_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_idx <= '0;
            dout    <= '0;
            wrap    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            cur_idx <= nxt_idx;
            dout    <= nxt_show ? dec_out : '0;
            wrap    <= nxt_wrap;
            busy    <= nxt_busy;
        end
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered successor to the 4-to-16 enable decoder.
- Converts a binary select into a one-hot output vector.
- Two modes:
  - DIRECT: registered decode of `sel_in`.
  - SCAN: autonomous cyclic sweep of all outputs with a programmable dwell time.
- Drives row/digit strobes in display and multiplexing logic; sits between control logic and output pads.

Parameters:
- SEL_W, 4, select width in bits.
- OUT_W, 16, number of one-hot outputs; legal range 2..2**SEL_W.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, block enable; low forces outputs off.
- mode, input, 1, 0 = DIRECT, 1 = SCAN.
- sel_in, input, SEL_W, select code used in DIRECT mode.
- dwell, input, DWELL_W, extra hold cycles per SCAN step; each index is held for dwell+1 cycles.
- dout, output, OUT_W, registered one-hot output; all zero when inactive.
- cur_idx, output, SEL_W, index currently asserted on dout.
- wrap, output, 1, one-cycle pulse when the scan returns to index 0.
- busy, output, 1, high while in SCAN state.

Behaviour:
- Reset (asynchronous, active-high, applied immediately):
  - dout=0, cur_idx=0, wrap=0, busy=0.
  - State IDLE; dwell counter 0.
  - Release is synchronous to the next clk edge.
- States: IDLE, DIRECT, SCAN (plus BLANK when BLANK_GAP_EN is defined).
- Transitions (evaluated each clk edge, in priority order):
  - en=0 -> IDLE from any state; dout=0 and cur_idx=0 on the next edge.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 from IDLE or DIRECT -> SCAN, starting at index 0 with dwell counter loaded.
  - Remains in SCAN while en=1 and mode=1.
- DIRECT:
  - Latency is 1 cycle: dout = one-hot(sel_in) and cur_idx = sel_in, from the previous edge.
  - If sel_in >= OUT_W: dout=0 and cur_idx=sel_in.
  - wrap=0, busy=0.
- SCAN:
  - dout = one-hot(cur_idx); busy=1.
  - `dwell` is sampled when each step begins; a change takes effect at the next step, never mid-step.
  - Each index is held for dwell+1 cycles. dwell=0 advances every cycle.
  - After index OUT_W-1 the index wraps to 0. wrap=1 in exactly the cycle dout first shows index 0 after a wrap; the initial entry does not pulse wrap.
  - Index and dwell counter are modular, using SEL_W and DWELL_W widths. Comparison against OUT_W-1 allows OUT_W to be non-power-of-2.
- Mode change mid-scan (mode 1->0 with en=1):
  - Next edge enters DIRECT and shows one-hot(sel_in).
  - Scan position is discarded; re-entering SCAN restarts at index 0.
- Simultaneous events: reset overrides everything; en=0 overrides mode.
- Invariant: dout has at most one bit set in every cycle.

Optional Feature:
- Macro: SCAN_DECODER_BLANK_GAP_EN.
- Defined:
  - In SCAN, a single BLANK cycle is inserted after each step's dwell expires.
  - During BLANK, dout=0 and cur_idx holds the previous index; busy stays 1.
  - The next index is asserted after BLANK, so a full sweep takes OUT_W*(dwell+2) cycles.
  - wrap pulses on the cycle index 0 appears after BLANK.
  - en/mode/reset priorities are unchanged, including from BLANK.
- Undefined: no BLANK state exists; a sweep takes OUT_W*(dwell+1) cycles.

Decomposition:
- Package scan_decoder_pkg holds:
  - state enum type (IDLE, DIRECT, SCAN, BLANK);
  - constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
- Sub-module onehot_decoder (parameters SEL_W, OUT_W):
  - purely combinational decode with an out-of-range zero output;
  - instantiated once; the parent registers its output.

Test Plan:
- Reset: assert rst mid-cycle with en=1, mode=1 -> dout=0, busy=0, wrap=0 immediately, before the next edge; after release the scan restarts at index 0.
- DIRECT sweep: en=1, mode=0, sel_in 0..15, each held 2 cycles -> dout=16'h0001<<sel_in one edge later; with OUT_W=10 and sel_in=12 -> dout=0.
- Enable gating: en=0 with sel_in=5 -> dout=0, cur_idx=0; en back to 1 -> dout=16'h0020 after one edge.
- SCAN, dwell=0: dout steps 0x0001,0x0002,...,0x8000, then 0x0001 with wrap=1 on cycle 16 after entry; wrap is never asserted otherwise.
- SCAN, dwell=2: each index is held 3 cycles and wrap occurs at cycle 48. Changing dwell to 0 mid-step alters only the following steps.
- BLANK gap (macro defined), dwell=1: per step the pattern is 2 cycles one-hot then 1 cycle zero; wrap at cycle 48. Mode 1->0 mid-scan gives dout=one-hot(sel_in) on the next edge.
